// File: rtl/htif_mbox.sv
// HTIF tohost/fromhost mailbox on APB: decodes console-putchar and exit commands,
// buffers console characters in a small FIFO and pulses an exit event with its code.
module htif_mbox #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [3:0]            pstrb,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  output logic                  pready,
  output logic                  char_valid,
  output logic [7:0]            char_data,
  input  logic                  char_ready,
  output logic                  exit_valid,
  output logic [31:0]           exit_code
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_TLO = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_THI = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] A_FLO = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] A_FHI = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_STS = ADDR_WIDTH'(32'h10);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_PUSH, S_EXIT, S_CLEAR} state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  state_e state_q, state_d;
  logic [31:0] tohost_lo_q, tohost_lo_d, tohost_hi_q, tohost_hi_d;
  logic [31:0] fromhost_lo_q, fromhost_lo_d, fromhost_hi_q, fromhost_hi_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        exit_seen_q, exit_seen_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]  mem [FIFO_DEPTH];

  logic access, sel_tlo, sel_thi, sel_flo, sel_fhi, sel_sts, mapped;
  logic busy, wr_en, commit, full, push_en, pop, exit_load;
  logic [31:0] hi_wr, status;

  assign access  = psel & penable;
  assign sel_tlo = (paddr == A_TLO);
  assign sel_thi = (paddr == A_THI);
  assign sel_flo = (paddr == A_FLO);
  assign sel_fhi = (paddr == A_FHI);
  assign sel_sts = (paddr == A_STS);
  assign mapped  = sel_tlo | sel_thi | sel_flo | sel_fhi | sel_sts;

  // TOHOST is locked while a command is in flight so the decoded value cannot change under the FSM
  assign pslverr = access & (~mapped | (pwrite & sel_sts) | (pwrite & (sel_tlo | sel_thi) & busy));
  assign wr_en   = access & pwrite & ~pslverr;
  assign hi_wr   = merge_bytes(tohost_hi_q, pwdata, pstrb);
  assign commit  = wr_en & sel_thi & ((hi_wr | tohost_lo_q) != 32'h0);
  assign pready  = 1'b1;

  assign full       = (level_q == DEPTH_L);
  assign char_valid = (level_q != '0);
  assign char_data  = mem[rd_ptr_q];
  assign pop        = char_valid & char_ready;
  assign exit_code  = exit_code_q;
  assign status     = {21'h0, busy, exit_seen_q, full, 8'(level_q)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (commit) state_d = S_DECODE;
      S_DECODE: begin
        if (tohost_hi_q[31:24] == 8'h01 && tohost_hi_q[23:16] == 8'h01) state_d = S_PUSH;
        else if (tohost_hi_q == 32'h0)                                    state_d = S_EXIT;
        else                                                              state_d = S_CLEAR;
      end
      S_PUSH:   if (!full) state_d = S_CLEAR;
      S_EXIT:   state_d = S_CLEAR;
      S_CLEAR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    exit_valid = (state_q == S_EXIT);
    push_en    = (state_q == S_PUSH) && !full;
    exit_load  = (state_q == S_DECODE) && (state_d == S_EXIT);
  end

  always_comb begin
    tohost_lo_d   = tohost_lo_q;
    tohost_hi_d   = tohost_hi_q;
    fromhost_lo_d = fromhost_lo_q;
    fromhost_hi_d = fromhost_hi_q;
    exit_code_d   = exit_code_q;
    exit_seen_d   = exit_seen_q;
    if (state_q == S_CLEAR) begin
      tohost_lo_d = 32'h0;
      tohost_hi_d = 32'h0;
    end else begin
      if (wr_en && sel_tlo) tohost_lo_d = merge_bytes(tohost_lo_q, pwdata, pstrb);
      if (wr_en && sel_thi) tohost_hi_d = hi_wr;
    end
    if (wr_en && sel_flo) fromhost_lo_d = merge_bytes(fromhost_lo_q, pwdata, pstrb);
    if (wr_en && sel_fhi) fromhost_hi_d = merge_bytes(fromhost_hi_q, pwdata, pstrb);
    if (exit_load) begin
      exit_code_d = tohost_lo_q;
      exit_seen_d = 1'b1;
    end
  end

  // Full is judged on the registered level, so a pop in the same cycle frees the slot only next cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push_en) - LVL_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_lo_q   <= 32'h0;
      tohost_hi_q   <= 32'h0;
      fromhost_lo_q <= 32'h0;
      fromhost_hi_q <= 32'h0;
      exit_code_q   <= 32'h0;
      exit_seen_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      tohost_lo_q   <= tohost_lo_d;
      tohost_hi_q   <= tohost_hi_d;
      fromhost_lo_q <= fromhost_lo_d;
      fromhost_hi_q <= fromhost_hi_d;
      exit_code_q   <= exit_code_d;
      exit_seen_q   <= exit_seen_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= tohost_lo_q[7:0];
  end

  always_comb begin
    prdata = 32'h0;
    if (access) begin
      if (sel_tlo) prdata = tohost_lo_q;
      if (sel_thi) prdata = tohost_hi_q;
      if (sel_flo) prdata = fromhost_lo_q;
      if (sel_fhi) prdata = fromhost_hi_q;
      if (sel_sts) prdata = status;
    end
  end

endmodule

// File: tb/tb_htif_mbox.sv
// Directed bench for htif_mbox: putchar latency, FIFO full stall, exit event,
// ignored commands, APB errors/strobes and reset during a stalled push.
module tb_htif_mbox;
  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata, exit_code;
  logic        pslverr, pready, char_valid, char_ready, exit_valid;
  logic [7:0]  char_data;

  int tests = 0;
  int fails = 0;
  int exit_cnt = 0;

  htif_mbox #(.FIFO_DEPTH(8), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .pready(pready), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .exit_valid(exit_valid),
    .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (exit_valid) exit_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle access phase driven from a negedge; returns at the following negedge
  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a; pstrb = 4'h0;
    #1 d = prdata; e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic e);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    #1 e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                    input logic exp_e);
    logic [31:0] d;
    logic e;
    apb_rd(a, d, e);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic exp_e);
    logic e;
    apb_wr(a, d, s, e);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    logic e;
    logic [31:0] ok;
    ok = 32'h0;
    for (int i = 0; i < 30; i++) begin
      apb_rd(12'h004, d, e);
      if (d == 32'h0) begin
        ok = 32'h1;
        break;
      end
    end
    check(tag, ok, 32'h1);
  endtask

  task automatic send_char(input logic [7:0] c);
    logic e;
    apb_wr(12'h000, {24'h0, c}, 4'hF, e);
    apb_wr(12'h004, 32'h0101_0000, 4'hF, e);
    wait_idle("send_idle");
  endtask

  initial begin
    logic [7:0] exp_q [9];
    int idx;
    int e0;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pstrb = 4'h0; pwdata = 32'h0; char_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_char_valid", 32'(char_valid), 32'h0);
    check("rst_exit_valid", 32'(exit_valid), 32'h0);
    check("rst_exit_code",  exit_code, 32'h0);
    check("rst_pready",     32'(pready), 32'h1);
    check("rst_pslverr",    32'(pslverr), 32'h0);
    check("rst_prdata",     prdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd("rst_status", 12'h010, 32'h0, 1'b0);
    rd("rst_tohost_lo", 12'h000, 32'h0, 1'b0);

    // putchar 'A': commit at T, decode T+1, push T+2, visible T+3, TOHOST zero at T+4
    wr("t1_lo", 12'h000, 32'h41, 4'hF, 1'b0);
    wr("t1_hi", 12'h004, 32'h0101_0000, 4'hF, 1'b0);
    rd("t1_status_busy", 12'h010, 32'h400, 1'b0);
    check("t1_noval_t2", 32'(char_valid), 32'h0);
    @(negedge clk);
    check("t1_val_t3",  32'(char_valid), 32'h1);
    check("t1_data_t3", 32'(char_data), 32'h41);
    rd("t1_lo_t3", 12'h000, 32'h41, 1'b0);
    check("t1_popped", 32'(char_valid), 32'h0);
    rd("t1_hi_t4", 12'h004, 32'h0, 1'b0);
    rd("t1_lo_t5", 12'h000, 32'h0, 1'b0);

    // FIFO full stall with 9 chars and no downstream ready
    char_ready = 1'b0;
    for (int i = 0; i < 9; i++) exp_q[i] = 8'h61 + 8'(i);
    for (int i = 0; i < 8; i++) send_char(exp_q[i]);
    wr("t2_lo9", 12'h000, {24'h0, exp_q[8]}, 4'hF, 1'b0);
    wr("t2_hi9", 12'h004, 32'h0101_0000, 4'hF, 1'b0);
    repeat (2) @(negedge clk);
    rd("t2_status_full", 12'h010, 32'h508, 1'b0);
    wr("t2_tohost_busy", 12'h000, 32'h77, 4'hF, 1'b1);
    rd("t2_lo_kept", 12'h000, 32'h69, 1'b0);
    check("t2_head", 32'(char_data), 32'h61);
    char_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && idx < 9; c++) begin
      if (char_valid) begin
        check($sformatf("t2_char%0d", idx), 32'(char_data), 32'(exp_q[idx]));
        idx++;
      end
      @(negedge clk);
    end
    check("t2_count", 32'(idx), 32'd9);
    wait_idle("t2_idle");
    check("t2_empty", 32'(char_valid), 32'h0);

    // exit command
    e0 = exit_cnt;
    wr("t3_lo", 12'h000, 32'h1, 4'hF, 1'b0);
    wr("t3_hi", 12'h004, 32'h0, 4'hF, 1'b0);
    check("t3_noexit_t1", 32'(exit_valid), 32'h0);
    @(negedge clk);
    check("t3_exit_t2", 32'(exit_valid), 32'h1);
    check("t3_code_t2", exit_code, 32'h1);
    @(negedge clk);
    check("t3_exit_t3", 32'(exit_valid), 32'h0);
    check("t3_code_held", exit_code, 32'h1);
    rd("t3_status_clear", 12'h010, 32'h600, 1'b0);
    rd("t3_status_idle", 12'h010, 32'h200, 1'b0);
    check("t3_one_pulse", 32'(exit_cnt - e0), 32'h1);

    // unknown device is ignored: no char, no exit, level unchanged
    char_ready = 1'b0;
    send_char(8'h5A);
    rd("t4_status_pre", 12'h010, 32'h201, 1'b0);
    e0 = exit_cnt;
    wr("t4_lo", 12'h000, 32'h5, 4'hF, 1'b0);
    wr("t4_hi", 12'h004, 32'hFF00_0000, 4'hF, 1'b0);
    wait_idle("t4_idle");
    check("t4_no_exit", 32'(exit_cnt - e0), 32'h0);
    rd("t4_lo_clr", 12'h000, 32'h0, 1'b0);
    rd("t4_status_post", 12'h010, 32'h201, 1'b0);
    check("t4_head", 32'(char_data), 32'h5A);
    char_ready = 1'b1;
    @(negedge clk);
    check("t4_drained", 32'(char_valid), 32'h0);

    // LO-only nonzero write does not commit
    wr("t4b_lo", 12'h000, 32'h42, 4'hF, 1'b0);
    rd("t4b_not_busy", 12'h010, 32'h200, 1'b0);
    wr("t4b_lo_clr", 12'h000, 32'h0, 4'hF, 1'b0);

    // APB errors and byte strobes
    rd("t5_unmapped", 12'h020, 32'h0, 1'b1);
    wr("t5_wr_status", 12'h010, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd("t5_status_same", 12'h010, 32'h200, 1'b0);
    wr("t5_fh_lo", 12'h008, 32'hAABB_CCDD, 4'h2, 1'b0);
    rd("t5_fh_lo_rd", 12'h008, 32'h0000_CC00, 1'b0);
    wr("t5_fh_hi", 12'h00C, 32'h1234_5678, 4'hF, 1'b0);
    rd("t5_fh_hi_rd", 12'h00C, 32'h1234_5678, 1'b0);

    // reset while the 9th push is stalled on a full FIFO
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_char(8'h30 + 8'(i));
    wr("t6_lo9", 12'h000, 32'h38, 4'hF, 1'b0);
    wr("t6_hi9", 12'h004, 32'h0101_0000, 4'hF, 1'b0);
    repeat (2) @(negedge clk);
    rd("t6_status_full", 12'h010, 32'h708, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(char_valid), 32'h0);
    check("t6_rst_exit_code", exit_code, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd("t6_status", 12'h010, 32'h0, 1'b0);
    rd("t6_hi", 12'h004, 32'h0, 1'b0);
    rd("t6_lo", 12'h000, 32'h0, 1'b0);
    rd("t6_fh_lo", 12'h008, 32'h0, 1'b0);
    check("t6_still_empty", 32'(char_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
